dram_seq: RTL and testbench

//   Page-mode DRAM cycle sequencer; sits downstream of the row-address bank

---
 rtl/dram_seq.sv | 223 ++++++++++++++++++++++
 tb/tb_dram_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dram_seq.sv
// ============================================================================
//  Module   : dram_seq
//  Purpose  : Page-mode DRAM cycle sequencer (page hit / page miss / CBR refresh)
//  Options  : DRAM_REFRESH_EN builds the CAS-before-RAS refresh path
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dram_seq #(
  parameter int unsigned TRP  = 2,
  parameter int unsigned TRCD = 2,
  parameter int unsigned TCAS = 2,
  parameter int unsigned TRAS = 3
) (
  input  logic clk,
  input  logic resl,
  input  logic req,
  input  logic rw,
  input  logic match,
  input  logic refreq,
  output logic ack,
  output logic refack,
  output logic newrow,
  output logic rasl,
  output logic casl,
  output logic wel,
  output logic colsel,
  output logic busy
);

  // Counter load values: a state lasting N cycles loads N-1; zero timings act as one.
  localparam logic [3:0] c_trp_ld  = (TRP  == 0) ? 4'd0 : 4'(TRP  - 1);
  localparam logic [3:0] c_trcd_ld = (TRCD == 0) ? 4'd0 : 4'(TRCD - 1);
  localparam logic [3:0] c_tcas_ld = (TCAS == 0) ? 4'd0 : 4'(TCAS - 1);
`ifdef DRAM_REFRESH_EN
  localparam logic [3:0] c_tras_ld = (TRAS == 0) ? 4'd0 : 4'(TRAS - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRECH   = 3'd1,
    S_ROW     = 3'd2,
    S_COL     = 3'd3
`ifdef DRAM_REFRESH_EN
    ,
    S_REF_CBR = 3'd4,
    S_REF_RAS = 3'd5,
    S_REF_REC = 3'd6
`endif
  } state_t;

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_pageopen;
  logic       r_rw;
`ifdef DRAM_REFRESH_EN
  logic       r_to_ref;
`else
  logic       w_unused_refreq;
  assign w_unused_refreq = refreq;
`endif

  always_ff @(posedge clk or negedge resl) begin
    if (!resl) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_pageopen <= 1'b0;
      r_rw       <= 1'b1;
`ifdef DRAM_REFRESH_EN
      r_to_ref   <= 1'b0;
`endif
      rasl       <= 1'b1;
      casl       <= 1'b1;
      wel        <= 1'b1;
      newrow     <= 1'b0;
      ack        <= 1'b0;
      refack     <= 1'b0;
      colsel     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      newrow <= 1'b0;
      ack    <= 1'b0;
      refack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          casl <= 1'b1;
`ifdef DRAM_REFRESH_EN
          if (refreq) begin
            busy <= 1'b1;
            if (r_pageopen) begin
              r_state    <= S_PRECH;
              r_cnt      <= c_trp_ld;
              rasl       <= 1'b1;
              r_pageopen <= 1'b0;
              r_to_ref   <= 1'b1;
            end else begin
              r_state <= S_REF_CBR;
              rasl    <= 1'b1;
              casl    <= 1'b0;
            end
          end else
`endif
          if (req) begin
            busy <= 1'b1;
            r_rw <= rw;
            if (r_pageopen && match) begin
              r_state <= S_COL;
              r_cnt   <= c_tcas_ld;
              colsel  <= 1'b1;
              casl    <= 1'b0;
              wel     <= rw;
              ack     <= (c_tcas_ld == 4'd0);
            end else if (r_pageopen) begin
              r_state    <= S_PRECH;
              r_cnt      <= c_trp_ld;
              rasl       <= 1'b1;
              r_pageopen <= 1'b0;
            end else begin
              r_state    <= S_ROW;
              r_cnt      <= c_trcd_ld;
              newrow     <= 1'b1;
              rasl       <= 1'b0;
              colsel     <= 1'b0;
              r_pageopen <= 1'b1;
            end
          end
        end

        S_PRECH: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
`ifdef DRAM_REFRESH_EN
            if (r_to_ref) begin
              r_state  <= S_REF_CBR;
              casl     <= 1'b0;
              r_to_ref <= 1'b0;
            end else
`endif
            begin
              r_state    <= S_ROW;
              r_cnt      <= c_trcd_ld;
              newrow     <= 1'b1;
              rasl       <= 1'b0;
              colsel     <= 1'b0;
              r_pageopen <= 1'b1;
            end
          end
        end

        S_ROW: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= S_COL;
            r_cnt   <= c_tcas_ld;
            colsel  <= 1'b1;
            casl    <= 1'b0;
            wel     <= r_rw;
            ack     <= (c_tcas_ld == 4'd0);
          end
        end

        // Leaving COL keeps rasl low so the page stays open for a later hit.
        S_COL: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
            ack   <= (r_cnt == 4'd1);
          end else begin
            r_state <= S_IDLE;
            casl    <= 1'b1;
            wel     <= 1'b1;
            colsel  <= 1'b0;
            busy    <= 1'b0;
          end
        end

`ifdef DRAM_REFRESH_EN
        S_REF_CBR: begin
          r_state <= S_REF_RAS;
          r_cnt   <= c_tras_ld;
          rasl    <= 1'b0;
        end

        S_REF_RAS: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= S_REF_REC;
            r_cnt   <= c_trp_ld;
            rasl    <= 1'b1;
            casl    <= 1'b1;
            refack  <= (c_trp_ld == 4'd0);
          end
        end

        S_REF_REC: begin
          if (r_cnt != 4'd0) begin
            r_cnt  <= r_cnt - 4'd1;
            refack <= (r_cnt == 4'd1);
          end else begin
            r_state    <= S_IDLE;
            r_pageopen <= 1'b0;
            busy       <= 1'b0;
          end
        end
`endif

        default: begin
          r_state <= S_IDLE;
          rasl    <= 1'b1;
          casl    <= 1'b1;
          wel     <= 1'b1;
          colsel  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dram_seq.sv
// Self-checking bench for dram_seq: scoreboarded accesses, refresh and reset abort.
`default_nettype none

module tb_dram_seq;

  localparam int TRP  = 2;
  localparam int TRCD = 2;
  localparam int TCAS = 2;
  localparam int TRAS = 3;

  logic clk = 1'b0;
  logic resl = 1'b0;
  logic req = 1'b0;
  logic rw = 1'b1;
  logic match = 1'b0;
  logic refreq = 1'b0;
  logic ack, refack, newrow, rasl, casl, wel, colsel, busy;

  int n_checks = 0;
  int n_pass = 0;
  bit model_open = 1'b0;

  typedef struct packed {
    int lat;
    int nrow;
    int rasl_hi;
    int wel;
    int gap;
  } exp_t;

  exp_t sb[$];

  dram_seq #(.TRP(TRP), .TRCD(TRCD), .TCAS(TCAS), .TRAS(TRAS)) dut (
    .clk    (clk),
    .resl   (resl),
    .req    (req),
    .rw     (rw),
    .match  (match),
    .refreq (refreq),
    .ack    (ack),
    .refack (refack),
    .newrow (newrow),
    .rasl   (rasl),
    .casl   (casl),
    .wel    (wel),
    .colsel (colsel),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic do_access(input string tag, input logic rwv, input logic mv, input bit keep);
    exp_t e;
    int   edges = 0;
    int   nrow = 0;
    int   rhi = 0;
    int   wbad = 0;
    int   nb = 0;
    int   t_nr = -1;
    int   t_cs = -1;
    logic wcas = 1'b1;
    bit   got = 1'b0;
    e.lat     = model_open ? (mv ? 1 + TCAS : 1 + TRP + TRCD + TCAS) : 1 + TRCD + TCAS;
    e.nrow    = (model_open && mv) ? 0 : 1;
    e.rasl_hi = (model_open && !mv) ? TRP : 0;
    e.wel     = int'(rwv);
    e.gap     = TRCD;
    sb.push_back(e);
    rw    = rwv;
    match = mv;
    req   = 1'b1;
    while (!got && edges < 64) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 1) match = ~mv;  // comparator changes after IDLE must be ignored
      if (newrow) begin
        nrow++;
        if (t_nr < 0) t_nr = edges;
      end
      if (colsel && t_cs < 0) t_cs = edges;
      if (rasl) rhi++;
      if (!casl) wcas = wel;
      else if (!wel) wbad++;
      if (!busy) nb++;
      if (ack) got = 1'b1;
    end
    if (!keep) req = 1'b0;
    e = sb.pop_front();
    check({tag, "_ack_seen"}, int'(got), 1);
    check({tag, "_latency"}, edges + 1, e.lat);
    check({tag, "_newrow_cnt"}, nrow, e.nrow);
    check({tag, "_rasl_high"}, rhi, e.rasl_hi);
    check({tag, "_wel_cas"}, int'(wcas), e.wel);
    check({tag, "_wel_outside"}, wbad, 0);
    check({tag, "_busy"}, nb, 0);
    if (e.nrow != 0) check({tag, "_trcd_gap"}, t_cs - t_nr, e.gap);
    model_open = 1'b1;
    @(posedge clk); #1;
    check({tag, "_idle_after"}, int'({ack, busy, casl, colsel, wel, rasl}), int'(6'b001010));
  endtask

  initial begin
    int acks;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_pins", int'({rasl, casl, wel, newrow, ack, refack, colsel, busy}), int'(8'b1110_0000));
    @(negedge clk) resl = 1'b1;
    @(posedge clk); #1;
    check("reset_release", int'({rasl, casl, wel, newrow, ack, refack, colsel, busy}), int'(8'b1110_0000));

    do_access("rd_closed", 1'b1, 1'b0, 1'b0);
    do_access("wr_hit", 1'b0, 1'b1, 1'b1);
    do_access("rd_hit_b2b", 1'b1, 1'b1, 1'b0);
    do_access("rd_miss_open", 1'b1, 1'b0, 1'b0);
    do_access("wr_miss_open", 1'b0, 1'b0, 1'b0);

`ifdef DRAM_REFRESH_EN
    begin
      int edges = 0;
      int cf = -1;
      int rf = -1;
      int ackbad = 0;
      bit seen_hi = 1'b0;
      bit got = 1'b0;
      rw     = 1'b1;
      match  = 1'b1;
      req    = 1'b1;
      refreq = 1'b1;
      while (!got && edges < 64) begin
        @(posedge clk); #1;
        edges++;
        if (rasl) seen_hi = 1'b1;
        if (seen_hi && !casl && cf < 0) cf = edges;
        if (seen_hi && !rasl && rf < 0) rf = edges;
        if (ack) ackbad++;
        if (refack) got = 1'b1;
      end
      refreq = 1'b0;
      check("ref_done", int'(got), 1);
      check("ref_latency", edges + 1, 1 + TRP + 1 + TRAS + TRP);
      check("ref_cbr_order", int'(cf > 0 && rf > cf), 1);
      check("ref_no_ack", ackbad, 0);
      model_open = 1'b0;
      @(posedge clk); #1;
      check("ref_idle", int'({busy, rasl, casl, refack}), int'(4'b0110));
      do_access("rd_after_ref", 1'b1, 1'b1, 1'b0);
    end
`endif

    // Reset in the middle of a page-hit write
    rw    = 1'b0;
    match = 1'b1;
    req   = 1'b1;
    @(posedge clk); #1;
    check("abort_in_col", int'({casl, colsel, wel}), int'(3'b010));
    #2 resl = 1'b0;
    #1;
    check("abort_pins", int'({rasl, casl, wel}), int'(3'b111));
    check("abort_pulses", int'({ack, busy, colsel, newrow}), 0);
    req   = 1'b0;
    acks  = 0;
    repeat (3) begin
      @(posedge clk); #1;
      acks += int'(ack);
    end
    check("abort_no_ack", acks, 0);
    @(negedge clk) resl = 1'b1;
    model_open = 1'b0;
    @(posedge clk); #1;
    do_access("rd_after_abort", 1'b1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
